// File: rtl/systolic_sched_pkg.sv
// Shared FSM state encoding and tile geometry helper for the systolic tile scheduler.
// Imported by systolic_tile_scheduler.
package systolic_sched_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ISSUE = 3'd1,
    GUARD = 3'd2,
    WAIT  = 3'd3,
    ADV   = 3'd4,
    FIN   = 3'd5
  } sched_state_e;

  // Words occupied by one NxN tile; consecutive tiles are this far apart.
  function automatic int unsigned tile_stride(input int unsigned n);
    return n * n;
  endfunction

endpackage

// File: rtl/systolic_tile_scheduler.sv
// Walks an M_T x N_T grid of NxN tiles row-major, one start/done handshake per tile; done 2 cycles after last sa_done.
// Optional busy-cycle counter on perf_cycles when SCHED_PERF_EN is defined; otherwise perf_cycles is 0.
module systolic_tile_scheduler
  import systolic_sched_pkg::*;
#(
  parameter int N             = 4,
  parameter int ADDRESS_WIDTH = 13,
  parameter int TILE_W        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cmd_valid,
  output logic                     cmd_ready,
  input  logic [TILE_W-1:0]        cmd_m_tiles,
  input  logic [TILE_W-1:0]        cmd_n_tiles,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base_w,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base_x,
  input  logic [ADDRESS_WIDTH-1:0] cmd_base_out,
  input  logic                     cmd_abort,
  output logic                     sa_start,
  input  logic                     sa_done,
  output logic [ADDRESS_WIDTH-1:0] sa_base_addr_w,
  output logic [ADDRESS_WIDTH-1:0] sa_base_addr_x,
  output logic [ADDRESS_WIDTH-1:0] sa_base_addr_out,
  output logic                     busy,
  output logic                     done,
  output logic [2*TILE_W-1:0]      tiles_done,
  output logic [31:0]              perf_cycles
);

  localparam logic [ADDRESS_WIDTH-1:0] STRIDE_A = ADDRESS_WIDTH'(tile_stride(N));
  localparam int LIN_W = 2 * TILE_W;

  sched_state_e state_q, state_d;

  logic [TILE_W-1:0]        m_q, m_d;
  logic [TILE_W-1:0]        n_q, n_d;
  logic [TILE_W-1:0]        i_q, i_d;
  logic [TILE_W-1:0]        j_q, j_d;
  logic [ADDRESS_WIDTH-1:0] base_w_q, base_w_d;
  logic [ADDRESS_WIDTH-1:0] base_x_q, base_x_d;
  logic [ADDRESS_WIDTH-1:0] base_out_q, base_out_d;
  logic [ADDRESS_WIDTH-1:0] addr_w_q, addr_w_d;
  logic [ADDRESS_WIDTH-1:0] addr_x_q, addr_x_d;
  logic [ADDRESS_WIDTH-1:0] addr_out_q, addr_out_d;
  logic [LIN_W-1:0]         tiles_q, tiles_d;
  logic                     abort_pend_q, abort_pend_d;

  logic                     accept;
  logic                     zero_cmd;
  logic                     last_tile;
  logic                     row_end;
  logic                     adv_go;
  logic [TILE_W-1:0]        i_nxt;
  logic [TILE_W-1:0]        j_nxt;
  logic [LIN_W-1:0]         lin_nxt;

  assign accept    = (state_q == IDLE) && cmd_valid;
  assign zero_cmd  = (cmd_m_tiles == '0) || (cmd_n_tiles == '0);
  assign row_end   = (j_q == n_q - TILE_W'(1));
  assign last_tile = (i_q == m_q - TILE_W'(1)) && row_end;
  assign adv_go    = (state_q == ADV) && !(abort_pend_q || last_tile);
  assign j_nxt     = row_end ? '0 : j_q + TILE_W'(1);
  assign i_nxt     = row_end ? i_q + TILE_W'(1) : i_q;
  assign lin_nxt   = LIN_W'(i_nxt) * LIN_W'(n_q) + LIN_W'(j_nxt);

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (cmd_valid) state_d = zero_cmd ? FIN : ISSUE;
      ISSUE:   state_d = GUARD;
      GUARD:   state_d = WAIT;
      WAIT:    if (sa_done) state_d = ADV;
      ADV:     state_d = (abort_pend_q || last_tile) ? FIN : ISSUE;
      FIN:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // ---------------- FSM: outputs ----------------
  always_comb begin
    cmd_ready = 1'b0;
    busy      = 1'b1;
    sa_start  = 1'b0;
    done      = 1'b0;
    case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
      end
      ISSUE:   sa_start = 1'b1;
      FIN:     done     = 1'b1;
      default: ;
    endcase
  end

  // ---------------- Datapath next state ----------------
  always_comb begin
    m_d          = m_q;
    n_d          = n_q;
    i_d          = i_q;
    j_d          = j_q;
    base_w_d     = base_w_q;
    base_x_d     = base_x_q;
    base_out_d   = base_out_q;
    addr_w_d     = addr_w_q;
    addr_x_d     = addr_x_q;
    addr_out_d   = addr_out_q;
    tiles_d      = tiles_q;
    abort_pend_d = abort_pend_q;

    if (accept) begin
      m_d        = cmd_m_tiles;
      n_d        = cmd_n_tiles;
      i_d        = '0;
      j_d        = '0;
      base_w_d   = cmd_base_w;
      base_x_d   = cmd_base_x;
      base_out_d = cmd_base_out;
      tiles_d    = '0;
      // Tile (0,0) addresses are just the bases; only loaded when a tile will actually issue.
      if (!zero_cmd) begin
        addr_w_d   = cmd_base_w;
        addr_x_d   = cmd_base_x;
        addr_out_d = cmd_base_out;
      end
    end

    if ((state_q == WAIT) && sa_done) tiles_d = tiles_q + LIN_W'(1);

    if (adv_go) begin
      i_d        = i_nxt;
      j_d        = j_nxt;
      addr_w_d   = base_w_q + ADDRESS_WIDTH'(i_nxt) * STRIDE_A;
      addr_x_d   = base_x_q + ADDRESS_WIDTH'(j_nxt) * STRIDE_A;
      addr_out_d = base_out_q + ADDRESS_WIDTH'(lin_nxt) * STRIDE_A;
    end

    // The current tile always runs to completion; abort only takes effect at ADV.
    if (state_q == FIN)          abort_pend_d = 1'b0;
    else if (busy && cmd_abort)  abort_pend_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      m_q          <= '0;
      n_q          <= '0;
      i_q          <= '0;
      j_q          <= '0;
      base_w_q     <= '0;
      base_x_q     <= '0;
      base_out_q   <= '0;
      addr_w_q     <= '0;
      addr_x_q     <= '0;
      addr_out_q   <= '0;
      tiles_q      <= '0;
      abort_pend_q <= 1'b0;
    end else begin
      m_q          <= m_d;
      n_q          <= n_d;
      i_q          <= i_d;
      j_q          <= j_d;
      base_w_q     <= base_w_d;
      base_x_q     <= base_x_d;
      base_out_q   <= base_out_d;
      addr_w_q     <= addr_w_d;
      addr_x_q     <= addr_x_d;
      addr_out_q   <= addr_out_d;
      tiles_q      <= tiles_d;
      abort_pend_q <= abort_pend_d;
    end
  end

  assign sa_base_addr_w   = addr_w_q;
  assign sa_base_addr_x   = addr_x_q;
  assign sa_base_addr_out = addr_out_q;
  assign tiles_done       = tiles_q;

`ifdef SCHED_PERF_EN
  logic [31:0] perf_q, perf_d;

  always_comb begin
    perf_d = perf_q;
    if (accept)                      perf_d = '0;
    else if (busy && (perf_q != '1)) perf_d = perf_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) perf_q <= '0;
    else     perf_q <= perf_d;
  end

  assign perf_cycles = perf_q;
`else
  assign perf_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_systolic_tile_scheduler.sv
// Scripted cycle-timeline model of the tile scheduler with randomized commands, waits and ignored-input noise.
// Expected outputs come from the grid walk and address arithmetic; one negedge process compares every cycle.
module tb_systolic_tile_scheduler;

  localparam int AW  = 13;
  localparam int TW  = 4;
  localparam int STR = 16;

  logic          clk = 1'b0;
  logic          rst;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [TW-1:0] cmd_m_tiles;
  logic [TW-1:0] cmd_n_tiles;
  logic [AW-1:0] cmd_base_w;
  logic [AW-1:0] cmd_base_x;
  logic [AW-1:0] cmd_base_out;
  logic          cmd_abort;
  logic          sa_start;
  logic          sa_done;
  logic [AW-1:0] sa_base_addr_w;
  logic [AW-1:0] sa_base_addr_x;
  logic [AW-1:0] sa_base_addr_out;
  logic          busy;
  logic          done;
  logic [2*TW-1:0] tiles_done;
  logic [31:0]   perf_cycles;

  always #5 clk = ~clk;

  systolic_tile_scheduler #(.N(4), .ADDRESS_WIDTH(AW), .TILE_W(TW)) dut (
    .clk              (clk),
    .rst              (rst),
    .cmd_valid        (cmd_valid),
    .cmd_ready        (cmd_ready),
    .cmd_m_tiles      (cmd_m_tiles),
    .cmd_n_tiles      (cmd_n_tiles),
    .cmd_base_w       (cmd_base_w),
    .cmd_base_x       (cmd_base_x),
    .cmd_base_out     (cmd_base_out),
    .cmd_abort        (cmd_abort),
    .sa_start         (sa_start),
    .sa_done          (sa_done),
    .sa_base_addr_w   (sa_base_addr_w),
    .sa_base_addr_x   (sa_base_addr_x),
    .sa_base_addr_out (sa_base_addr_out),
    .busy             (busy),
    .done             (done),
    .tiles_done       (tiles_done),
    .perf_cycles      (perf_cycles)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Expected outputs for the current cycle
  bit            e_vld = 1'b0;
  bit            e_ready, e_busy, e_start, e_done, e_addr_chk;
  int            e_tiles;
  logic [31:0]   e_perf;
  logic [AW-1:0] e_aw, e_ax, e_ao;

  // Model state
  int            tiles_m;
  logic [31:0]   perf_m;
  bit            accepting;
  int            noise_pct;

  logic [AW-1:0] log_w[$];
  logic [AW-1:0] log_x[$];
  logic [AW-1:0] log_o[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] amod(input int v);
    logic [31:0] t;
    t = v;
    return t[AW-1:0];
  endfunction

  always @(negedge clk) begin
    if (e_vld) begin
      chk("cmd_ready",  32'(cmd_ready),  32'(e_ready));
      chk("busy",       32'(busy),       32'(e_busy));
      chk("sa_start",   32'(sa_start),   32'(e_start));
      chk("done",       32'(done),       32'(e_done));
      chk("tiles_done", 32'(tiles_done), 32'(e_tiles));
      chk("perf",       perf_cycles,     e_perf);
      if (e_addr_chk) begin
        chk("addr_w",   32'(sa_base_addr_w),   32'(e_aw));
        chk("addr_x",   32'(sa_base_addr_x),   32'(e_ax));
        chk("addr_out", 32'(sa_base_addr_out), 32'(e_ao));
      end
    end
    if (sa_start === 1'b1) begin
      log_w.push_back(sa_base_addr_w);
      log_x.push_back(sa_base_addr_x);
      log_o.push_back(sa_base_addr_out);
    end
  end

  task automatic set_exp(input bit r, input bit b, input bit s, input bit d, input bit ac);
    e_ready    = r;
    e_busy     = b;
    e_start    = s;
    e_done     = d;
    e_addr_chk = ac;
    e_tiles    = tiles_m;
    e_perf     = perf_m;
    e_vld      = 1'b1;
  endtask

  task automatic cycle();
    @(posedge clk);
`ifdef SCHED_PERF_EN
    if (rst || accepting)                       perf_m = 32'd0;
    else if (e_busy && perf_m != 32'hFFFFFFFF) perf_m = perf_m + 32'd1;
`endif
    #1;
  endtask

  // Random command offers while busy; these must never be taken.
  task automatic noise();
    if ($urandom_range(99) < noise_pct) begin
      cmd_valid    = 1'b1;
      cmd_m_tiles  = TW'($urandom);
      cmd_n_tiles  = TW'($urandom);
      cmd_base_w   = AW'($urandom);
      cmd_base_x   = AW'($urandom);
      cmd_base_out = AW'($urandom);
    end else begin
      cmd_valid = 1'b0;
    end
  endtask

  task automatic finish_cmd();
    noise();
    sa_done = 1'($urandom_range(1));
    set_exp(0, 1, 0, 1, 0);
    cycle();
    cmd_valid = 1'b0;
    sa_done   = 1'($urandom_range(1));
    cmd_abort = 1'($urandom_range(1));
    set_exp(1, 0, 0, 0, 0);
    cycle();
    cmd_abort = 1'b0;
    sa_done   = 1'b0;
  endtask

  task automatic run_cmd(input int m, input int n, input int bw, input int bx, input int bo,
                         input int abort_at, input int rst_at, input int wait_d);
    int k;
    int d;
    cmd_valid    = 1'b1;
    cmd_m_tiles  = TW'(m);
    cmd_n_tiles  = TW'(n);
    cmd_base_w   = amod(bw);
    cmd_base_x   = amod(bx);
    cmd_base_out = amod(bo);
    cmd_abort    = 1'($urandom_range(1));
    sa_done      = 1'($urandom_range(1));
    accepting    = 1'b1;
    set_exp(1, 0, 0, 0, 0);
    cycle();
    accepting = 1'b0;
    cmd_abort = 1'b0;
    tiles_m   = 0;
    if (m == 0 || n == 0) begin
      finish_cmd();
      return;
    end
    k = 0;
    for (int i = 0; i < m; i++) begin
      for (int j = 0; j < n; j++) begin
        e_aw = amod(bw + i * STR);
        e_ax = amod(bx + j * STR);
        e_ao = amod(bo + (i * n + j) * STR);
        noise(); sa_done = 1'b0;
        set_exp(0, 1, 1, 0, 1); cycle();
        noise(); sa_done = 1'($urandom_range(1));
        set_exp(0, 1, 0, 0, 1); cycle();
        if (k == rst_at) begin
          noise(); sa_done = 1'b0; rst = 1'b1;
          set_exp(0, 1, 0, 0, 1); cycle();
          rst = 1'b0; cmd_valid = 1'b0;
          tiles_m = 0;
          e_aw = '0; e_ax = '0; e_ao = '0;
          set_exp(1, 0, 0, 0, 1); cycle();
          return;
        end
        d = (wait_d < 0) ? int'($urandom_range(3)) : wait_d;
        for (int w = 0; w < d; w++) begin
          noise(); sa_done = 1'b0;
          set_exp(0, 1, 0, 0, 1); cycle();
        end
        noise(); sa_done = 1'b1; cmd_abort = (k == abort_at);
        set_exp(0, 1, 0, 0, 1); cycle();
        tiles_m++;
        cmd_abort = 1'b0;
        noise(); sa_done = 1'($urandom_range(1));
        set_exp(0, 1, 0, 0, 0); cycle();
        if (k == abort_at || (i == m - 1 && j == n - 1)) begin
          finish_cmd();
          return;
        end
        k++;
      end
    end
  endtask

  task automatic clear_log();
    log_w.delete();
    log_x.delete();
    log_o.delete();
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd_abort = 1'b0; sa_done = 1'b0;
    cmd_m_tiles = '0; cmd_n_tiles = '0;
    cmd_base_w = '0; cmd_base_x = '0; cmd_base_out = '0;
    tiles_m = 0; perf_m = 32'd0; accepting = 1'b0; noise_pct = 0;
    e_aw = '0; e_ax = '0; e_ao = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    set_exp(1, 0, 0, 0, 1);
    cycle();

    // Single tile
    clear_log();
    run_cmd(1, 1, 'h000, 'h100, 'h010, -1, -1, 0);
    chk("t1_starts", 32'(log_w.size()), 32'd1);
    chk("t1_addr_x", 32'(log_x[0]), 32'h100);
    chk("t1_addr_o", 32'(log_o[0]), 32'h010);
    chk("t1_tiles", 32'(tiles_done), 32'd1);
`ifdef SCHED_PERF_EN
    chk("t1_perf", perf_cycles, 32'd5);
`endif

    // 2x3 grid, row-major order
    noise_pct = 30;
    clear_log();
    run_cmd(2, 3, 'h000, 'h100, 'h010, -1, -1, -1);
    chk("t2_starts", 32'(log_w.size()), 32'd6);
    chk("t2_tile01_x", 32'(log_x[1]), 32'h110);
    chk("t2_tile10_w", 32'(log_w[3]), 32'h010);
    chk("t2_tile12_w", 32'(log_w[5]), 32'h010);
    chk("t2_tile12_x", 32'(log_x[5]), 32'h120);
    chk("t2_tile12_o", 32'(log_o[5]), 32'h060);
    chk("t2_tiles", 32'(tiles_done), 32'd6);

    // Zero tiles
    clear_log();
    run_cmd(0, 5, 'h000, 'h100, 'h010, -1, -1, -1);
    chk("t3_starts", 32'(log_w.size()), 32'd0);
    chk("t3_tiles", 32'(tiles_done), 32'd0);

    // Abort during second tile
    clear_log();
    run_cmd(2, 2, 'h000, 'h100, 'h010, 1, -1, -1);
    chk("t4_starts", 32'(log_w.size()), 32'd2);
    chk("t4_tiles", 32'(tiles_done), 32'd2);

    // Address wrap, with cmd_valid held high throughout
    noise_pct = 100;
    clear_log();
    run_cmd(1, 2, 'h000, 'h100, 'h1FF0, -1, -1, -1);
    chk("t5_starts", 32'(log_o.size()), 32'd2);
    chk("t5_wrap_o", 32'(log_o[1]), 32'h0000);
    noise_pct = 30;

    // Reset in WAIT, then a fresh command
    run_cmd(2, 2, 'h000, 'h100, 'h010, -1, 1, -1);
    chk("t6_rst_tiles", 32'(tiles_done), 32'd0);
    chk("t6_rst_ready", 32'(cmd_ready), 32'd1);
    clear_log();
    run_cmd(1, 1, 'h000, 'h100, 'h010, -1, -1, 1);
    chk("t6_starts", 32'(log_w.size()), 32'd1);
    chk("t6_tiles", 32'(tiles_done), 32'd1);

    // Randomized commands
    repeat (40) begin
      int m, n, ab;
      m  = int'($urandom_range(3));
      n  = int'($urandom_range(3));
      ab = ($urandom_range(3) == 0) ? int'($urandom_range(m * n)) : -1;
      run_cmd(m, n, int'($urandom_range(8191)), int'($urandom_range(8191)),
              int'($urandom_range(8191)), ab, -1, -1);
    end

    e_vld = 1'b0;
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
